// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM encoding and parity modes.
package uart_tx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_tx_cfg_sync_fifo.sv
// Synchronous FIFO with exact occupancy; full is judged on the pre-pop level so a push while full is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-fed UART transmitter with configurable data bits, parity and stop bits.
// state     | meaning
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (low)
// ST_DATA   | payload bits, LSB first
// ST_PARITY | parity bit (only when parity enabled)
// ST_STOP   | stop bit(s) high; done on the final cycle
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BPS        = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [7:0]                  data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        done,
  output logic                        txOut
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BPS;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LOAD = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LOAD = 3'(STOP_BITS - 1);
  localparam logic          ODD_INV   = 1'(PARITY == PAR_ODD);

  state_e                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   pop, start_frame, bit_end;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   unused_data_hi;

  assign unused_data_hi = ^data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (en),
    .wdata (data[DATA_BITS-1:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    pop         = 1'b0;
    done        = 1'b0;
    start_frame = 1'b0;
    bit_end     = (baud_q == '0);

    case (state_q)
      ST_IDLE: start_frame = !empty;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = DATA_LOAD;
        end else baud_d = baud_q - 1'b1;
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = BAUD_LOAD;
          if (bit_q == '0) begin
            if (PARITY != PAR_NONE) state_d = ST_PARITY;
            else begin
              state_d = ST_STOP;
              bit_d   = STOP_LOAD;
            end
          end else begin
            bit_d   = bit_q - 1'b1;
            shift_d = shift_q >> 1;
          end
        end else baud_d = baud_q - 1'b1;
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          baud_d  = BAUD_LOAD;
          bit_d   = STOP_LOAD;
        end else baud_d = baud_q - 1'b1;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == '0) begin
            done        = 1'b1;
            start_frame = !empty;
            if (empty) state_d = ST_IDLE;
          end else begin
            bit_d  = bit_q - 1'b1;
            baud_d = BAUD_LOAD;
          end
        end else baud_d = baud_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back frames reuse this path straight from the last stop cycle.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = ST_START;
      baud_d  = BAUD_LOAD;
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ ODD_INV;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign txOut = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: three configurations at 10 clocks per bit, line decoded mid-bit.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [7:0] din = 8'h00;

  logic       full_a, empty_a, busy_a, done_a, tx_a;
  logic [2:0] level_a;
  logic       full_b, empty_b, busy_b, done_b, tx_b;
  logic [4:0] level_b;
  logic       full_c, empty_c, busy_c, done_c, tx_c;
  logic [4:0] level_c;

  // A: 8N1 with a 4-entry FIFO, B: 7E2, C: 8O1
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .data(din), .full(full_a), .empty(empty_a),
    .level(level_a), .busy(busy_a), .done(done_a), .txOut(tx_a));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BPS(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .data(din), .full(full_b), .empty(empty_b),
    .level(level_b), .busy(busy_b), .done(done_b), .txOut(tx_b));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .data(din), .full(full_c), .empty(empty_c),
    .level(level_c), .busy(busy_c), .done(done_c), .txOut(tx_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0, n_err = 0;
  logic [15:0] exp_q[$];
  int          start_q[$];
  int          sel = 0, nbits = 10, frames_seen = 0;
  bit          mon_en = 1'b0, mon_act = 1'b0;
  int          busy_cnt_a = 0, busy_cnt_c = 0, done_cnt_a = 0, done_cnt_c = 0;
  logic [15:0] mon_got;
  logic        line;

  always_comb line = (sel == 0) ? tx_a : (sel == 1) ? tx_b : tx_c;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame bits as they appear on the line, index 0 = start bit.
  function automatic logic [15:0] mk_frame(logic [7:0] d, int db, int par, int sb);
    logic [15:0] f;
    int          p;
    logic        x;
    f = '0;
    p = 1;
    x = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[p] = d[i];
      x    = x ^ d[i];
      p++;
    end
    if (par != 0) begin
      f[p] = (par == 1) ? ~x : x;
      p++;
    end
    for (int i = 0; i < sb; i++) begin
      f[p] = 1'b1;
      p++;
    end
    return f;
  endfunction

  always @(negedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (busy_c) busy_cnt_c++;
    if (done_a) done_cnt_a++;
    if (done_c) done_cnt_c++;
  end

  // Line monitor: a low line while idle marks a start bit; each bit is sampled at its centre.
  always begin
    @(negedge clk);
    if (mon_en && line == 1'b0) begin
      mon_act = 1'b1;
      start_q.push_back(cyc);
      mon_got = '0;
      for (int k = 0; k < nbits; k++) begin
        repeat (5) @(negedge clk);
        mon_got[k] = line;
        if (k < nbits - 1) repeat (5) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      if (exp_q.size() == 0) check("unexpected_frame", 32'(exp_q.size()), 32'd1);
      else check("frame", 32'(mon_got), 32'(exp_q.pop_front()));
      frames_seen++;
      mon_act = 1'b0;
    end
  end

  task automatic drive_en(int inst, logic v, logic [7:0] d);
    din  = d;
    en_a = v && (inst == 0);
    en_b = v && (inst == 1);
    en_c = v && (inst == 2);
  endtask

  task automatic send(int inst, logic [7:0] d);
    @(posedge clk); #1;
    drive_en(inst, 1'b1, d);
    @(posedge clk); #1;
    drive_en(inst, 1'b0, 8'h00);
  endtask

  task automatic drain(int max_cyc);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || mon_act) && i < max_cyc) begin
      @(posedge clk);
      i++;
    end
    check("drain", 32'(exp_q.size() == 0 && !mon_act), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          en_cyc, b0, d0, f0;
    logic [15:0] f;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_a",    32'(tx_a),    32'd1);
    check("rst_busy_a",  32'(busy_a),  32'd0);
    check("rst_done_a",  32'(done_a),  32'd0);
    check("rst_level_a", 32'(level_a), 32'd0);
    check("rst_empty_a", 32'(empty_a), 32'd1);
    check("rst_full_a",  32'(full_a),  32'd0);
    check("rst_tx_b",    32'(tx_b),    32'd1);
    check("rst_tx_c",    32'(tx_c),    32'd1);
    mon_en = 1'b1;

    // 8N1 single byte: latency, bit pattern, busy length, done count
    sel = 0; nbits = 10; start_q.delete();
    b0 = busy_cnt_a; d0 = done_cnt_a;
    @(posedge clk); #1;
    drive_en(0, 1'b1, 8'hA5);
    en_cyc = cyc;
    exp_q.push_back(mk_frame(8'hA5, 8, 0, 1));
    @(posedge clk); #1;
    drive_en(0, 1'b0, 8'h00);
    drain(300);
    repeat (5) @(posedge clk);
    check("t1_start_latency", (start_q.size() > 0) ? 32'(start_q[0] - en_cyc) : 32'hFFFF_FFFF, 32'd2);
    check("t1_busy_cycles", 32'(busy_cnt_a - b0), 32'd100);
    check("t1_done_pulses", 32'(done_cnt_a - d0), 32'd1);

    // 7E2 parity both ways
    sel = 1; nbits = 11;
    exp_q.push_back(mk_frame(8'h03, 7, 2, 2));
    send(1, 8'h03);
    drain(400);
    exp_q.push_back(mk_frame(8'h07, 7, 2, 2));
    send(1, 8'h07);
    drain(400);

    // 8O1 back-to-back frames
    sel = 2; nbits = 11; start_q.delete();
    b0 = busy_cnt_c; d0 = done_cnt_c;
    @(posedge clk); #1;
    drive_en(2, 1'b1, 8'h00); exp_q.push_back(mk_frame(8'h00, 8, 1, 1));
    @(posedge clk); #1;
    drive_en(2, 1'b1, 8'hFF); exp_q.push_back(mk_frame(8'hFF, 8, 1, 1));
    @(posedge clk); #1;
    drive_en(2, 1'b1, 8'h55); exp_q.push_back(mk_frame(8'h55, 8, 1, 1));
    @(posedge clk); #1;
    drive_en(2, 1'b0, 8'h00);
    drain(600);
    repeat (5) @(posedge clk);
    check("t3_gap01", (start_q.size() >= 3) ? 32'(start_q[1] - start_q[0]) : 32'hFFFF_FFFF, 32'd110);
    check("t3_gap12", (start_q.size() >= 3) ? 32'(start_q[2] - start_q[1]) : 32'hFFFF_FFFF, 32'd110);
    check("t3_busy_cycles", 32'(busy_cnt_c - b0), 32'd330);
    check("t3_done_pulses", 32'(done_cnt_c - d0), 32'd3);

    // depth-4 FIFO overflow: sixth push dropped
    sel = 0; nbits = 10;
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive_en(0, 1'b1, 8'(8'h10 + i));
      if (i < 5) exp_q.push_back(mk_frame(8'(8'h10 + i), 8, 0, 1));
      else begin
        @(negedge clk);
        check("t4_full_before", 32'(full_a),  32'd1);
        check("t4_level_before", 32'(level_a), 32'd4);
      end
    end
    @(posedge clk); #1;
    drive_en(0, 1'b0, 8'h00);
    @(negedge clk);
    check("t4_level_after", 32'(level_a), 32'd4);
    check("t4_full_after",  32'(full_a),  32'd1);
    drain(800);
    repeat (150) @(posedge clk);
    check("t4_frames", 32'(frames_seen - f0), 32'd5);

    // reset during cycle 35 of a frame, with a second byte queued
    f = mk_frame(8'h3C, 8, 0, 1);
    exp_q.push_back((f & 16'h000F) | 16'h03F0);
    @(posedge clk); #1;
    drive_en(0, 1'b1, 8'h3C);
    @(posedge clk); #1;
    drive_en(0, 1'b1, 8'h81);
    @(posedge clk); #1;
    drive_en(0, 1'b0, 8'h00);
    @(negedge clk);
    check("t5_level_pre", 32'(level_a), 32'd1);
    repeat (35) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_tx",    32'(tx_a),    32'd1);
    check("t5_busy",  32'(busy_a),  32'd0);
    check("t5_level", 32'(level_a), 32'd0);
    check("t5_empty", 32'(empty_a), 32'd1);
    drain(200);
    exp_q.push_back(mk_frame(8'hC3, 8, 0, 1));
    send(0, 8'hC3);
    drain(300);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BPS, 9600, baud rate; CLKS_PER_BIT = CLK_FREQ/BPS (integer division), which SHALL be at least 4.
REQ-003 Parameter DATA_BITS, 8, payload bits per frame, legal range 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame, 1 or 2.
REQ-006 Parameter FIFO_DEPTH, 16, transmit FIFO entries; power of two, at least 2.
REQ-007 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port en, input, 1, write strobe; pushes data into the FIFO when accepted.
REQ-010 Port data, input, 8, byte to send; bits [7:DATA_BITS] are ignored.
REQ-011 Port full, output, 1, FIFO full; en is not accepted while high.
REQ-012 Port empty, output, 1, FIFO empty.
REQ-013 Port level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-014 Port busy, output, 1, frame in progress.
REQ-015 Port done, output, 1, one-cycle pulse at the end of each frame.
REQ-016 Port txOut, output, 1, serial line; idles high.

Function
REQ-017 A push is accepted when en=1 and full=0; an en while full SHALL be dropped with no state change.
REQ-018 Full is evaluated before the same cycle's pop, so a push while full is rejected even if a pop occurs that cycle.
REQ-019 level SHALL be exact: +1 on an accepted push, -1 on a pop, unchanged when both occur in the same cycle.
REQ-020 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE->START when empty=0: pop the head entry into the shift register, set busy=1, and clear the baud counter.
REQ-022 The first cycle of START drives txOut=0.
REQ-023 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at the start of each frame; there is no free-running tick.
REQ-024 DATA sends DATA_BITS bits, LSB first.
REQ-025 PARITY is skipped when PARITY=0; otherwise it sends XOR of the payload bits (even) or its inverse (odd).
REQ-026 STOP drives txOut=1 for STOP_BITS bit periods.
REQ-027 At the last cycle of STOP, done=1 for one cycle.
REQ-028 After that cycle, if empty=0, go directly to START with the next entry popped (no idle bit), busy staying high; otherwise go to IDLE with busy=0.
REQ-029 Frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-030 txOut SHALL be registered and glitch-free.
REQ-031 A push into an empty FIFO while IDLE starts the frame on the following cycle: start-bit low appears 2 cycles after the en cycle.
REQ-032 Pushes during a frame SHALL NOT disturb the frame in flight.

Reset
REQ-033 On rst=1 at a clock edge:
- FIFO flushed: level=0, empty=1, full=0.
- FSM goes to IDLE; baud and bit counters cleared.
- Outputs: txOut=1, busy=0, done=0.
REQ-034 Reset mid-frame SHALL abort the frame, with txOut high on the next cycle; rst has priority over en.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state encoding;
- the parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
REQ-036 The FIFO SHALL be one sub-module, sync_fifo, with parameters WIDTH and DEPTH and push/pop/full/empty/level ports.
REQ-037 The serialiser, baud counter and FSM SHALL reside in uart_tx_cfg.

Verification
REQ-038 The bench SHALL use CLK_FREQ=1_000_000, BPS=100_000 (10 cycles per bit) and cover:
REQ-039 8N1, push 0xA5 while idle -> start-bit low 2 cycles after en; line reads 0,1,0,1,0,0,1,0,1,1 over 100 cycles; done pulses once; busy high exactly 100 cycles.
REQ-040 7E2, push 0x03 -> 11 bits: 0, 1100000, parity 0, then 1,1; push 0x07 -> parity bit 1.
REQ-041 8O1, 3 back-to-back pushes 0x00/0xFF/0x55 -> three 110-cycle frames with no idle gap; busy continuously high; 3 done pulses; odd parity bits 1, 1, 1.
REQ-042 FIFO_DEPTH=4, 6 consecutive pushes while idle -> first byte popped, 4 queued, full=1, sixth push dropped; exactly 5 frames emitted.
REQ-043 rst asserted at cycle 35 of a frame -> txOut=1, busy=0, level=0 next cycle; a push after release sends a clean frame.
